// File: rtl/spi_master_cfg.sv
// spi_master_cfg: configurable SPI master with runtime divider, CPOL/CPHA modes, bit order and decoded chip selects
module spi_master_cfg #(
  parameter int DATA_W = 8,
  parameter int NUM_CS = 4,
  parameter int DIV_W  = 8,
  parameter int CS_W   = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] data_in,
  input  logic              cpol,
  input  logic              cpha,
  input  logic              lsb_first,
  input  logic [DIV_W-1:0]  clk_div,
  input  logic [CS_W-1:0]   cs_sel,
  output logic [DATA_W-1:0] data_out,
  output logic              busy,
  output logic              done,
  output logic              mosi,
  input  logic              miso,
  output logic              sclk,
  output logic [NUM_CS-1:0] cs_n
);
  localparam int EW = $clog2(2 * DATA_W);
  localparam logic [EW-1:0] LAST = EW'(2 * DATA_W - 1);

  typedef enum logic [1:0] {IDLE, SETUP, XFER, HOLD} state_t;

  state_t            state, state_nxt;
  logic [DIV_W-1:0]  cnt, div_r;
  logic [EW-1:0]     ecnt;
  logic [CS_W-1:0]   cs_r;
  logic              cpha_r, lsb_r, sclk_r, mosi_r;
  logic [DATA_W-1:0] tx_sr, rx_sr;
  logic              accept, half_end, fin, tick, lead, samp, drv;

  assign busy = state != IDLE;
  assign sclk = sclk_r;
  assign mosi = mosi_r;

  // State register; reset aborts any transfer without a done pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  end

  // Next state plus half-period strobes: tick is an sclk edge, lead marks it as the leading one
  always_comb begin
    accept    = start && state == IDLE;
    half_end  = cnt == div_r;
    fin       = state == HOLD && half_end;
    tick      = half_end && (state == SETUP || (state == XFER && ecnt != LAST));
    lead      = state == SETUP || ecnt[0];
    samp      = tick && (lead != cpha_r);
    drv       = tick && (lead == cpha_r);
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = accept ? SETUP : IDLE;
      SETUP:   state_nxt = half_end ? XFER : SETUP;
      XFER:    state_nxt = (half_end && ecnt == LAST) ? HOLD : XFER;
      HOLD:    state_nxt = half_end ? IDLE : HOLD;
      default: state_nxt = IDLE;
    endcase
  end

  // Latch config on accept, pace half-periods, toggle sclk, shift mosi out and miso in
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_r    <= '0;
      cs_r     <= '0;
      cpha_r   <= 1'b0;
      lsb_r    <= 1'b0;
      sclk_r   <= 1'b0;
      mosi_r   <= 1'b0;
      cnt      <= '0;
      ecnt     <= '0;
      tx_sr    <= '0;
      rx_sr    <= '0;
      data_out <= '0;
      done     <= 1'b0;
    end else begin
      if (accept) begin
        div_r  <= clk_div;
        cs_r   <= cs_sel;
        cpha_r <= cpha;
        lsb_r  <= lsb_first;
        sclk_r <= cpol;
        cnt    <= '0;
        ecnt   <= '0;
        tx_sr  <= cpha ? data_in : (lsb_first ? data_in >> 1 : data_in << 1);
        mosi_r <= cpha ? 1'b0 : (lsb_first ? data_in[0] : data_in[DATA_W-1]);
      end else if (state != IDLE) begin
        cnt <= half_end ? '0 : cnt + 1'b1;
        if (state == XFER && half_end) ecnt <= ecnt + 1'b1;
        if (tick) sclk_r <= ~sclk_r;
        if (drv) begin
          mosi_r <= lsb_r ? tx_sr[0] : tx_sr[DATA_W-1];
          tx_sr  <= lsb_r ? tx_sr >> 1 : tx_sr << 1;
        end
        if (samp) rx_sr <= lsb_r ? {miso, rx_sr[DATA_W-1:1]} : {rx_sr[DATA_W-2:0], miso};
        if (fin) begin
          data_out <= rx_sr;
          mosi_r   <= 1'b0;
        end
      end
      done <= fin;
    end
  end

  // Decode the latched slave index; out-of-range indices select nothing
  always_comb begin
    cs_n = '1;
    for (int i = 0; i < NUM_CS; i++)
      if (busy && cs_r == CS_W'(i)) cs_n[i] = 1'b0;
  end
endmodule

// File: tb/tb_spi_master_cfg.sv
// tb_spi_master_cfg: directed stimulus with an expected-response queue checked by a done-triggered monitor
module tb_spi_master_cfg;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] data_in = '0;
  logic       cpol = 1'b0, cpha = 1'b0, lsb_first = 1'b0;
  logic [7:0] clk_div = '0;
  logic [1:0] cs_sel = '0;
  logic [7:0] data_out;
  logic       busy, done, mosi, miso, sclk;
  logic [2:0] cs_n;

  spi_master_cfg #(.DATA_W(8), .NUM_CS(3), .DIV_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .data_in(data_in), .cpol(cpol), .cpha(cpha),
    .lsb_first(lsb_first), .clk_div(clk_div), .cs_sel(cs_sel), .data_out(data_out), .busy(busy),
    .done(done), .mosi(mosi), .miso(miso), .sclk(sclk), .cs_n(cs_n)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] rx;
    logic [7:0] mo;
    logic [2:0] cs;
    int         lat;
    int         t_busy;
    logic       cpol;
    logic       cpha;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // slave model: loopback, or presents sseq MSB-first in wire order, advancing after each sampling edge
  logic       loop_m = 1'b1, s_cpha = 1'b0, s_psclk = 1'b0, s_pcs = 1'b0;
  logic [7:0] sseq = '0;
  int         s_tog = 0, s_ns = 0;
  assign miso = loop_m ? mosi : (s_ns < 8 ? sseq[7 - s_ns] : 1'b0);
  always @(negedge clk) begin
    if (!(&cs_n) && s_pcs) begin
      if (sclk !== s_psclk) begin
        if (s_tog[0] == s_cpha) s_ns++;
        s_tog++;
      end
    end else begin
      s_tog = 0;
      s_ns  = 0;
    end
    s_psclk = sclk;
    s_pcs   = !(&cs_n);
  end

  // monitor: observes each transfer and checks it against the queue head when done pulses
  int         t_rise = 0, tog = 0;
  logic [7:0] lead_b = '0, trail_b = '0;
  logic [2:0] cs_seen = '1;
  logic       cs_bad = 1'b0, idle_s = 1'b0, pbusy = 1'b0, psclk = 1'b0;
  exp_t       e;
  always @(negedge clk) begin
    if (rst_n) begin
      if (busy && !pbusy) begin
        t_rise = cyc; tog = 0; lead_b = '0; trail_b = '0;
        cs_seen = cs_n; cs_bad = 1'b0; idle_s = sclk;
      end else if (busy) begin
        if (cs_n !== cs_seen) cs_bad = 1'b1;
        if (sclk !== psclk) begin
          if (tog[0] == 1'b0) lead_b = {lead_b[6:0], mosi};
          else trail_b = {trail_b[6:0], mosi};
          tog++;
        end
      end
      if (done) begin
        if (q.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          e = q.pop_front();
          chk("data_out", data_out, e.rx);
          chk("latency", cyc - t_rise, e.lat);
          chk("busy_start", t_rise, e.t_busy);
          chk("sclk_toggles", tog, 16);
          chk("cs_n_active", {cs_bad, cs_seen}, {1'b0, e.cs});
          chk("mosi_bits", e.cpha ? trail_b : lead_b, e.mo);
          chk("sclk_idle", idle_s, e.cpol);
          chk("done_busy", busy, 0);
          chk("done_cs_n", cs_n, 3'b111);
        end
      end
    end
    pbusy = rst_n && busy;
    psclk = sclk;
  end

  task automatic wait_done(input int n);
    int k = 0;
    while (!done && k < n) begin
      @(negedge clk);
      k++;
    end
    chk("done_seen", done, 1);
  endtask

  task automatic push(input logic [7:0] rx, mo, input logic [2:0] cs, input int lat, tb, input logic pol, ph);
    exp_t x;
    x.rx = rx; x.mo = mo; x.cs = cs; x.lat = lat; x.t_busy = tb; x.cpol = pol; x.cpha = ph;
    q.push_back(x);
  endtask

  task automatic go(input logic [7:0] d, input logic pol, ph, lsb, input logic [7:0] div,
                    input logic [1:0] cs, input logic lp, input logic [7:0] sq,
                    input logic [7:0] rx, mo, input logic [2:0] csx, input int lat);
    loop_m = lp; sseq = sq; s_cpha = ph;
    push(rx, mo, csx, lat, cyc + 1, pol, ph);
    data_in = d; cpol = pol; cpha = ph; lsb_first = lsb; clk_div = div; cs_sel = cs; start = 1'b1;
    @(negedge clk);
    start = 1'b0; data_in = ~d; cpol = ~pol; cpha = ~ph; lsb_first = ~lsb; clk_div = 8'd0; cs_sel = ~cs;
    wait_done(lat + 8);
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c, nd;
    repeat (3) @(negedge clk);
    chk("rst_data_out", data_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_mosi", mosi, 0);
    chk("rst_sclk", sclk, 0);
    chk("rst_cs_n", cs_n, 3'b111);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    go(8'hA5, 0, 0, 0, 8'd0, 2'd0, 1, 8'h00, 8'hA5, 8'hA5, 3'b110, 18);
    go(8'h3C, 1, 1, 0, 8'd3, 2'd1, 0, 8'hC3, 8'hC3, 8'h3C, 3'b101, 72);
    go(8'h01, 0, 1, 1, 8'd1, 2'd2, 0, 8'h01, 8'h80, 8'h80, 3'b011, 36);
    loop_m = 1'b1; s_cpha = 1'b0;
    c = cyc;
    push(8'h96, 8'h96, 3'b110, 18, c + 1, 0, 0);
    push(8'h11, 8'h11, 3'b110, 18, c + 20, 0, 0);
    data_in = 8'h96; cpol = 0; cpha = 0; lsb_first = 0; clk_div = 8'd0; cs_sel = 2'd0; start = 1'b1;
    repeat (5) @(negedge clk);
    data_in = 8'h11;
    while (cyc < c + 20) @(negedge clk);
    start = 1'b0;
    wait_done(30);
    @(negedge clk);
    go(8'h5A, 0, 0, 0, 8'd0, 2'd3, 1, 8'h00, 8'h5A, 8'h5A, 3'b111, 18);
    c = cyc;
    data_in = 8'hF0; cpol = 0; cpha = 0; lsb_first = 0; clk_div = 8'd0; cs_sel = 2'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (cyc < c + 7) @(negedge clk);
    chk("pre_reset_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_cs_n", cs_n, 3'b111);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_sclk", sclk, 0);
    chk("mid_rst_data_out", data_out, 0);
    chk("mid_rst_done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    nd = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("no_done_after_reset", nd, 0);
    chk("queue_empty", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/spi_master_cfg.md
# spi_master_cfg

Parametrised SPI master: the next-generation serial core. It adds over the existing fixed 8-bit shifter:
- configurable word width;
- runtime clock divider;
- all four CPOL/CPHA modes;
- MSB/LSB-first ordering;
- multiple decoded chip selects;
- a one-cycle completion pulse.

It sits between a register/command front-end and the external SPI pins. Its handshake is start/busy-compatible with the existing core.

## Interface
Parameters:
- DATA_W, 8, bits per transfer (≥2)
- NUM_CS, 4, number of chip-select outputs (≥1)
- DIV_W, 8, width of clk_div
- CS_W, max(1,$clog2(NUM_CS)), width of cs_sel (derived)

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request transfer; accepted only when busy=0
- data_in  in  DATA_W  word to transmit, latched on accept
- cpol  in  1  idle sclk level, latched on accept
- cpha  in  1  0: sample leading edge; 1: sample trailing edge; latched on accept
- lsb_first  in  1  bit order, latched on accept
- clk_div  in  DIV_W  half-period = clk_div+1 clk cycles, latched on accept
- cs_sel  in  CS_W  target slave index, latched on accept
- data_out  out  DATA_W  last received word
- busy  out  1  transfer in progress
- done  out  1  one-cycle pulse at transfer end
- mosi  out  1  serial out
- miso  in  1  serial in
- sclk  out  1  serial clock
- cs_n  out  NUM_CS  active-low selects

## Operation
- States: IDLE → SETUP → XFER → HOLD → IDLE.
- Reset values: data_out=0, busy=0, done=0, mosi=0, sclk=0, cs_n=all 1s, state IDLE.
- IDLE outputs: sclk=latched cpol (0 after reset), cs_n all high, mosi=0.
- Accept: start=1 and busy=0. All config inputs and data_in are latched at that edge. They are ignored at any other time, including start while busy.
- SETUP: one half-period with cs_n[cs_sel]=0 and sclk=cpol.
  - CPHA=0: first data bit is on mosi from SETUP entry.
- XFER: 2·DATA_W half-periods; sclk toggles at each half-period boundary.
  - CPHA=0: miso sampled on leading (odd) edges; mosi shifts to the next bit on trailing edges.
  - CPHA=1: mosi updates on leading edges; miso sampled on trailing edges.
- Bit order: MSB first when lsb_first=0, else LSB first. Received bits are assembled in the same order, so loopback returns the identical word.
- HOLD: one half-period; sclk back at cpol; cs_n still asserted.
- End of transfer, in one cycle:
  - cs_n all high;
  - data_out loaded with the received word;
  - done=1;
  - busy=0.
- data_out holds until the next done.
- cs_sel ≥ NUM_CS: no cs_n line asserts; the transfer otherwise runs normally and done still pulses.
- Reset mid-transfer: immediate return to IDLE with reset values; no done pulse.

## Timing
- H = clk_div+1 (clk_div=0 gives sclk = clk/2).
- start sampled at edge T: busy=1 and cs_n low from T+1.
- done=1 and busy=0 in cycle T+1+H·(2·DATA_W+2). DATA_W=8, clk_div=0: T+19.
- Back-to-back: start during the done cycle is accepted. cs_n is high for exactly that one cycle, then the next transfer's SETUP begins.
- mosi is stable ≥H−1 cycles before every sampling sclk edge. miso is sampled on the clk edge that produces the sampling sclk edge.
- sclk has no glitches. There are exactly DATA_W full periods per transfer.

## Test plan
- Mode 0, clk_div=0, cs_sel=0, data_in=0xA5, miso looped to mosi → cs_n=4'b1110 during transfer, 8 sclk rising edges, done at T+19, data_out=0xA5.
- Mode 3 (cpol=1, cpha=1), clk_div=3, data_in=0x3C, slave model returns 0xC3 → sclk idles high, half-period 4 cycles, done at T+73, data_out=0xC3, mosi bits observed 0,0,1,1,1,1,0,0.
- lsb_first=1, mode 1, data_in=0x01, slave returns 0x80 LSB-first → first mosi bit 1, data_out=0x80.
- start held high throughout a transfer with data_in changed mid-transfer → only one transfer; shifted word equals the value at accept; a second transfer begins exactly one cycle after done (cs_n high one cycle).
- rst_n pulsed low at cycle T+7 of a mode-0 transfer → same-cycle cs_n=all 1s, busy=0, sclk=0, data_out=0, no done pulse.
- cs_sel=3 with NUM_CS=3 → cs_n stays 3'b111, sclk still toggles 8 periods, done pulses at T+19.
